alu_md_ctrl: RTL and testbench
==============================

// Module: alu_md_ctrl
// PURPOSE
//  EX-stage ALU control with RV32M multiply/divide sequencing. Decodes ALUSel for the base ALU
//  from ALUOp/inst, detects M-extension ops, and runs an iterative shift-add multiplier /
//  restoring divider. The pipeline is stalled until the result is ready.
//  Sits between the main control unit (ALUOp) and the EX stage; md_result is muxed into the EX result.
// PARAMETERS
//  XLEN    32  operand/result width
//  UNROLL  1   bits retired per iteration (1, 2 or 4); must divide XLEN
//  MD_EN   1   0: M ops not recognised; FSM tied off, stall=0, md_sel=0, md_done=0
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous, active-high reset
//  inst       in   32    instruction in EX
//  ALUOp      in   2     00 add, 01 sub, 10 funct3 decode, 11 pass
//  valid_in   in   1     inst in EX is valid (not a bubble)
//  flush      in   1     squash EX this cycle
//  rs1_val    in   XLEN  forwarded operand 1
//  rs2_val    in   XLEN  forwarded operand 2
//  ALUSel     out  4     base-ALU operation select
//  stall      out  1     hold PC, IF/ID and ID/EX
//  md_sel     out  1     EX result is md_result (high in DONE only)
//  md_done    out  1     one-cycle pulse: md_result valid
//  md_result  out  XLEN  mul/div result
// BEHAVIOUR
//  ALUSel (comb): ALUOp 00 ADD; 01 SUB; 11 PASS; 10 by funct3: 000 SUB if inst[5]&inst[30] else ADD,
//   100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRA if inst[30] else SRL, 010 SLT, 011 SLTU.
//   For M ops ALUSel=PASS (unused).
//  is_md = MD_EN & ALUOp==10 & inst[6:0]==0110011 & inst[31:25]==0000001.
//   funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  start = valid_in & is_md & state==IDLE & ~flush.
//  FSM IDLE -> MUL|DIV -> DONE -> IDLE.
//   IDLE: on start, latch |operands| and result-sign flags; cnt=0; go to MUL or DIV.
//    Special divides skip iteration and go straight to DONE:
//     div-by-zero: quotient all-ones, remainder = rs1.
//     signed overflow (min / -1): quotient = min, remainder = 0.
//   MUL/DIV: UNROLL bits per cycle; cnt++; after XLEN/UNROLL iterations go to DONE.
//   DONE: apply sign correction. md_result = low word (MUL), high word (MULH*), quotient or remainder.
//    Remainder takes the dividend's sign. md_done=1, md_sel=1, stall=0; next state IDLE.
//  stall = ~rst & ~flush & (start | state in {MUL,DIV}).
//  Latency: stall high for 1+XLEN/UNROLL cycles (1 for special divides); DONE is the following cycle.
//  Back-to-back M ops: the 2nd reaches EX after DONE and starts from IDLE; there is no idle gap beyond DONE.
//  flush in any state: next state IDLE, no md_done, stall=0 in the same cycle.
//  rst (any time): state IDLE, cnt 0, md_result 0, md_done 0, md_sel 0, stall 0.
//  Operands are sampled only at start; later rs1/rs2 changes are ignored.
// STRUCTURE
//  defines.v: existing ALU_* and F3_* codes; add F3_MUL..F3_REMU, OPC_OP, F7_MULDIV, MD_* state encodings.
//  One sub-module, md_iter_datapath: shift-add/restoring-divide registers with UNROLL steps per cycle.
//  alu_md_ctrl holds the decode, FSM, counter and sign handling.
// TESTING
//  MUL 7*(-3) -> stall 33 cycles, then md_done with md_result=0xFFFFFFEB, md_sel=1.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000;
//   MULHSU -1*2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF, REMU 7%0 -> 7, stall 1 cycle.
//  DIV 0x80000000/-1 -> 0x80000000, REM -> 0, stall 1 cycle.
//  flush at iteration 10 -> stall low that cycle, no md_done, IDLE next.
//   rst mid-op -> all outputs 0. A following MUL 3*4 -> 12.
//  Decode regression: ADD/SUB (inst[30]=1, inst[5]=1 -> SUB; ADDI with inst[30]=1 -> ADD),
//   SRAI -> SRA, ALUOp 11 -> PASS, MD_EN=0 build with M op -> stall never asserts.

Source files
------------

// File: rtl/alu_md_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_ctrl_pkg
//  Purpose  : Shared encodings for the EX-stage ALU control / RV32M sequencer:
//             base-ALU select codes, funct3 codes, opcode/funct7 constants
//             and the mul/div FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_md_ctrl_pkg;

  // Base-ALU operation select driven on ALUSel.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_sel_e;

  // Base integer funct3 codes.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // M-extension funct3 codes.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Operand-A is treated as signed for everything except the unsigned forms.
  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // Operand-B is signed only where operand-A is, minus MULHSU.
  function automatic logic f3_b_signed(input logic [2:0] f3);
    return f3_a_signed(f3) && (f3 != F3_MULHSU);
  endfunction

endpackage : alu_md_ctrl_pkg
`default_nettype wire

// File: rtl/alu_md_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_ctrl_if
//  Purpose  : EX-stage bundle between the pipeline and alu_md_ctrl.
//  Ports    : master (pipeline side) drives inst, ALUOp, valid_in, flush,
//             rs1_val, rs2_val and observes ALUSel, stall, md_sel, md_done,
//             md_result; slave (alu_md_ctrl) is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_md_ctrl_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst;
  logic [1:0]      ALUOp;
  logic            valid_in;
  logic            flush;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      ALUSel;
  logic            stall;
  logic            md_sel;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output inst, ALUOp, valid_in, flush, rs1_val, rs2_val,
    input  ALUSel, stall, md_sel, md_done, md_result
  );

  modport slave (
    input  inst, ALUOp, valid_in, flush, rs1_val, rs2_val,
    output ALUSel, stall, md_sel, md_done, md_result
  );
endinterface : alu_md_ctrl_if
`default_nettype wire

// File: rtl/alu_md_ctrl_md_iter_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_ctrl_md_iter_datapath
//  Purpose  : Unsigned iterative shift-add multiplier / restoring divider,
//             retiring UNROLL bits per step.
//             Multiply: {hi,lo} ends as the 2*XLEN product of a*b.
//             Divide  : lo ends as the quotient a/b, hi as the remainder.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             load              capture a (into lo) and b, clear hi
//             step              advance UNROLL iterations
//             div_mode          1: divide step, 0: multiply step
//             a, b              operand magnitudes
//             hi, lo            working registers / results
//  Revision : 1.0  initial release
// ============================================================================
module alu_md_ctrl_md_iter_datapath #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] h, l;
  logic [XLEN:0]   sh, sum;

  // Unrolled iteration chain. In both modes hi never needs a carry bit
  // between steps: the partial product high half and the partial remainder
  // (< divisor) each fit in XLEN bits, so the extra bit lives only in sh/sum.
  always_comb begin
    h   = hi_q;
    l   = lo_q;
    sh  = '0;
    sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (div_mode) begin
        sh = {h, l[XLEN-1]};
        l  = {l[XLEN-2:0], 1'b0};
        if (sh >= {1'b0, b_q}) begin
          h    = sh[XLEN-1:0] - b_q;
          l[0] = 1'b1;
        end else begin
          h = sh[XLEN-1:0];
        end
      end else begin
        sum = {1'b0, h} + (l[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        l   = {sum[0], l[XLEN-1:1]};
        h   = sum[XLEN:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= a;
      b_q  <= b;
    end else if (step) begin
      hi_q <= h;
      lo_q <= l;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule : alu_md_ctrl_md_iter_datapath
`default_nettype wire

// File: rtl/alu_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_ctrl
//  Purpose  : EX-stage ALU control. Decodes ALUSel from ALUOp/inst, detects
//             RV32M ops and sequences the iterative mul/div datapath,
//             stalling the pipeline until the result is ready.
//  Ports    : clk        clock
//             rst        synchronous, active-high reset
//             bus        alu_md_ctrl_if.slave: inst, ALUOp, valid_in, flush,
//                        rs1_val, rs2_val in; ALUSel, stall, md_sel,
//                        md_done, md_result out
//  Revision : 1.0  initial release
// ============================================================================
module alu_md_ctrl
  import alu_md_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int MD_EN  = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_md_ctrl_if.slave  bus
);

  logic [2:0] f3;
  logic       is_md;
  alu_sel_e   alu_sel;

  assign f3    = bus.inst[14:12];
  assign is_md = (MD_EN != 0) && (bus.ALUOp == 2'b10) &&
                 (bus.inst[6:0] == OPC_OP) && (bus.inst[31:25] == F7_MULDIV);

  // Register indices and rd are not part of the decode.
  logic unused_inst_fields;
  assign unused_inst_fields = ^{bus.inst[24:15], bus.inst[11:7]};

  // ---------------------------------------------------------------- decode
  always_comb begin
    alu_sel = ALU_ADD;
    case (bus.ALUOp)
      2'b00: alu_sel = ALU_ADD;
      2'b01: alu_sel = ALU_SUB;
      2'b11: alu_sel = ALU_PASS;
      default: begin
        if (is_md) begin
          alu_sel = ALU_PASS;
        end else begin
          case (f3)
            // inst[5] separates R-type from I-type so ADDI never becomes SUB.
            F3_ADD_SUB: alu_sel = (bus.inst[5] && bus.inst[30]) ? ALU_SUB : ALU_ADD;
            F3_XOR:     alu_sel = ALU_XOR;
            F3_OR:      alu_sel = ALU_OR;
            F3_AND:     alu_sel = ALU_AND;
            F3_SLL:     alu_sel = ALU_SLL;
            F3_SRL_SRA: alu_sel = bus.inst[30] ? ALU_SRA : ALU_SRL;
            F3_SLT:     alu_sel = ALU_SLT;
            default:    alu_sel = ALU_SLTU;
          endcase
        end
      end
    endcase
  end

  assign bus.ALUSel = alu_sel;

  // ------------------------------------------------------- mul/div sequencer
  generate
    if (MD_EN != 0) begin : g_md
      localparam int ITERS = XLEN / UNROLL;
      localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
      localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

      md_state_e       state;
      logic [CNT_W-1:0] cnt;
      logic [2:0]      op_f3;
      logic            a_neg;
      logic            res_neg;
      logic            special;
      logic [XLEN-1:0] spec_q;
      logic [XLEN-1:0] spec_r;

      logic            start;
      logic            op_is_div, op_a_neg, op_b_neg;
      logic            div_zero, div_ovf;
      logic [XLEN-1:0] a_mag, b_mag;
      logic [XLEN-1:0] dp_hi, dp_lo;
      logic            iterating, done;

      assign start     = bus.valid_in && is_md && (state == MD_IDLE) && !bus.flush;
      assign op_is_div = f3[2];
      assign op_a_neg  = f3_a_signed(f3) && bus.rs1_val[XLEN-1];
      assign op_b_neg  = f3_b_signed(f3) && bus.rs2_val[XLEN-1];
      assign a_mag     = op_a_neg ? -bus.rs1_val : bus.rs1_val;
      assign b_mag     = op_b_neg ? -bus.rs2_val : bus.rs2_val;
      assign div_zero  = op_is_div && (bus.rs2_val == '0);
      assign div_ovf   = op_is_div && f3_a_signed(f3) &&
                         (bus.rs1_val == MIN_VAL) && (bus.rs2_val == '1);
      assign iterating = (state == MD_MUL) || (state == MD_DIV);

      alu_md_ctrl_md_iter_datapath #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
      ) u_md_iter_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .step     (iterating),
        .div_mode (state == MD_DIV),
        .a        (a_mag),
        .b        (b_mag),
        .hi       (dp_hi),
        .lo       (dp_lo)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          state   <= MD_IDLE;
          cnt     <= '0;
          op_f3   <= F3_MUL;
          a_neg   <= 1'b0;
          res_neg <= 1'b0;
          special <= 1'b0;
          spec_q  <= '0;
          spec_r  <= '0;
        end else if (bus.flush) begin
          state <= MD_IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            MD_IDLE: begin
              if (start) begin
                op_f3   <= f3;
                a_neg   <= op_a_neg;
                res_neg <= op_a_neg ^ op_b_neg;
                cnt     <= '0;
                special <= div_zero || div_ovf;
                if (div_zero) begin
                  spec_q <= '1;
                  spec_r <= bus.rs1_val;
                  state  <= MD_DONE;
                end else if (div_ovf) begin
                  spec_q <= MIN_VAL;
                  spec_r <= '0;
                  state  <= MD_DONE;
                end else begin
                  state <= op_is_div ? MD_DIV : MD_MUL;
                end
              end
            end
            MD_MUL, MD_DIV: begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                state <= MD_DONE;
              end
            end
            default: begin
              state <= MD_IDLE;
            end
          endcase
        end
      end

      // Sign correction on the unsigned magnitudes held by the datapath.
      logic [2*XLEN-1:0] prod, prod_c;
      logic [XLEN-1:0]   quo_c, rem_c, result;

      always_comb begin
        prod   = {dp_hi, dp_lo};
        prod_c = res_neg ? -prod : prod;
        quo_c  = res_neg ? -dp_lo : dp_lo;
        rem_c  = a_neg ? -dp_hi : dp_hi;  // remainder follows the dividend
        case (op_f3)
          F3_MUL:                       result = prod_c[XLEN-1:0];
          F3_MULH, F3_MULHSU, F3_MULHU: result = prod_c[2*XLEN-1:XLEN];
          F3_DIV, F3_DIVU:              result = special ? spec_q : quo_c;
          default:                      result = special ? spec_r : rem_c;
        endcase
      end

      assign done          = !rst && !bus.flush && (state == MD_DONE);
      assign bus.stall     = !rst && !bus.flush && (start || iterating);
      assign bus.md_done   = done;
      assign bus.md_sel    = done;
      assign bus.md_result = done ? result : '0;
    end else begin : g_no_md
      logic unused_md_off;
      assign unused_md_off = ^{clk, rst, bus.valid_in, bus.flush,
                               bus.rs1_val, bus.rs2_val};
      assign bus.stall     = 1'b0;
      assign bus.md_done   = 1'b0;
      assign bus.md_sel    = 1'b0;
      assign bus.md_result = '0;
    end
  endgenerate

endmodule : alu_md_ctrl
`default_nettype wire

// File: tb/tb_alu_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_md_ctrl
//  Purpose  : Self-checking bench for alu_md_ctrl (MD_EN=1 instance plus an
//             MD_EN=0 instance for the tied-off build).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_md_ctrl;
  import alu_md_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_md_ctrl_if #(.XLEN(32)) bus  ();
  alu_md_ctrl_if #(.XLEN(32)) bus0 ();

  alu_md_ctrl #(.XLEN(32), .UNROLL(1), .MD_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  alu_md_ctrl #(.XLEN(32), .UNROLL(1), .MD_EN(0)) dut_nomd (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Issue one M op, count stall cycles until md_done, compare with scoreboard.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall, input string name);
    int   stalls;
    bit   got;
    logic [31:0] e;
    sb.push_back(exp);
    @(negedge clk);
    bus.inst = mk_r(F7_MULDIV, f3);
    bus.ALUOp = 2'b10;
    bus.valid_in = 1'b1;
    bus.flush = 1'b0;
    bus.rs1_val = a;
    bus.rs2_val = b;
    stalls = 0;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (c == 1) begin
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
      end
      if (bus.stall) stalls++;
      if (bus.md_done) begin
        got = 1;
        e = sb.pop_front();
        checks++;
        if (bus.md_sel !== 1'b1) begin
          errors++;
          $display("FAIL %s md_sel: got %b want 1", name, bus.md_sel);
        end
        checks++;
        if (bus.md_result !== e) begin
          errors++;
          $display("FAIL %s result: got %h want %h", name, bus.md_result, e);
        end
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL %s timeout: no md_done within 100 cycles", name);
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.inst = mk_r(F7_MULDIV, F3_MUL);
    bus.ALUOp = 2'b10;
    bus.valid_in = 1'b1;  // M op present during reset must not stall
    bus.flush = 1'b0;
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd6;
    bus0.inst = 32'h0;
    bus0.ALUOp = 2'b00;
    bus0.valid_in = 1'b0;
    bus0.flush = 1'b0;
    bus0.rs1_val = '0;
    bus0.rs2_val = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.md_done, bus.md_sel} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got stall/done/sel=%b want 000",
               {bus.stall, bus.md_done, bus.md_sel});
    end
    checks++;
    if (bus.md_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h want 00000000", bus.md_result);
    end
    bus.valid_in = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [3:0] tab [8];
    tab[0] = ALU_ADD;  tab[1] = ALU_SLL; tab[2] = ALU_SLT; tab[3] = ALU_SLTU;
    tab[4] = ALU_XOR;  tab[5] = ALU_SRL; tab[6] = ALU_OR;  tab[7] = ALU_AND;
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.ALUOp = 2'b10;
    for (int i = 0; i < 8; i++) begin
      bus.inst = mk_r(7'b0000000, 3'(i));
      #1;
      checks++;
      if (bus.ALUSel !== tab[i]) begin
        errors++;
        $display("FAIL decode_rtype_f3_%0d: got %0d want %0d", i, bus.ALUSel, tab[i]);
      end
    end
    bus.inst = mk_r(7'b0100000, F3_ADD_SUB);
    #1;
    checks++;
    if (bus.ALUSel !== ALU_SUB) begin
      errors++;
      $display("FAIL decode_sub: got %0d want %0d", bus.ALUSel, ALU_SUB);
    end
    bus.inst = {12'h400, 5'd1, 3'b000, 5'd3, 7'b0010011};
    #1;
    checks++;
    if (bus.ALUSel !== ALU_ADD) begin
      errors++;
      $display("FAIL decode_addi_b30: got %0d want %0d", bus.ALUSel, ALU_ADD);
    end
    bus.inst = {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd3, 7'b0010011};
    #1;
    checks++;
    if (bus.ALUSel !== ALU_SRA) begin
      errors++;
      $display("FAIL decode_srai: got %0d want %0d", bus.ALUSel, ALU_SRA);
    end
    bus.inst = mk_r(F7_MULDIV, F3_DIV);
    #1;
    checks++;
    if (bus.ALUSel !== ALU_PASS) begin
      errors++;
      $display("FAIL decode_mop_pass: got %0d want %0d", bus.ALUSel, ALU_PASS);
    end
    bus.inst = mk_r(7'b0100000, F3_ADD_SUB);
    bus.ALUOp = 2'b00;
    #1;
    checks++;
    if (bus.ALUSel !== ALU_ADD) begin
      errors++;
      $display("FAIL decode_aluop00: got %0d want %0d", bus.ALUSel, ALU_ADD);
    end
    bus.ALUOp = 2'b01;
    #1;
    checks++;
    if (bus.ALUSel !== ALU_SUB) begin
      errors++;
      $display("FAIL decode_aluop01: got %0d want %0d", bus.ALUSel, ALU_SUB);
    end
    bus.ALUOp = 2'b11;
    #1;
    checks++;
    if (bus.ALUSel !== ALU_PASS) begin
      errors++;
      $display("FAIL decode_aluop11: got %0d want %0d", bus.ALUSel, ALU_PASS);
    end
  endtask

  task automatic test_mul();
    run_md(F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7xm3");
    go_idle();
    run_md(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max");
    go_idle();
    run_md(F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min");
    go_idle();
    run_md(F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1x2");
    go_idle();
  endtask

  task automatic test_div();
    run_md(F3_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_m7_2");
    go_idle();
    run_md(F3_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_m7_2");
    go_idle();
    run_md(F3_DIVU, 32'd100,      32'd7, 32'd14,       33, "divu_100_7");
    go_idle();
    run_md(F3_REMU, 32'd100,      32'd7, 32'd2,        33, "remu_100_7");
    go_idle();
  endtask

  task automatic test_div_special();
    run_md(F3_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 1, "divu_by0");
    go_idle();
    run_md(F3_REMU, 32'd7,        32'd0,        32'd7,        1, "remu_by0");
    go_idle();
    run_md(F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    go_idle();
    run_md(F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");
    go_idle();
  endtask

  task automatic test_back_to_back();
    run_md(F3_MUL, 32'd1000, 32'd1000, 32'd1000000, 33, "b2b_mul");
    run_md(F3_DIV, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, 33, "b2b_div");
    go_idle();
  endtask

  task automatic test_flush();
    bit seen_done;
    bit seen_stall;
    @(negedge clk);
    bus.inst = mk_r(F7_MULDIV, F3_MUL);
    bus.ALUOp = 2'b10;
    bus.valid_in = 1'b1;
    bus.flush = 1'b0;
    bus.rs1_val = 32'd9;
    bus.rs2_val = 32'd9;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.md_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: got stall=%b done=%b want 0 0", bus.stall, bus.md_done);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.valid_in = 1'b0;
    seen_done = 0;
    seen_stall = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.md_done) seen_done = 1;
      if (bus.stall) seen_stall = 1;
      @(negedge clk);
    end
    checks++;
    if (seen_done || seen_stall) begin
      errors++;
      $display("FAIL flush_after: got done=%b stall=%b want 0 0", seen_done, seen_stall);
    end
    run_md(F3_MUL, 32'd5, 32'd6, 32'd30, 33, "post_flush_mul");
    go_idle();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.inst = mk_r(F7_MULDIV, F3_DIVU);
    bus.ALUOp = 2'b10;
    bus.valid_in = 1'b1;
    bus.rs1_val = 32'd50;
    bus.rs2_val = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.md_done, bus.md_sel} !== 3'b000 || bus.md_result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_op: got stall/done/sel=%b result=%h want 000 00000000",
               {bus.stall, bus.md_done, bus.md_sel}, bus.md_result);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    checks++;
    if ({bus.stall, bus.md_done, bus.md_sel} !== 3'b000) begin
      errors++;
      $display("FAIL rst_after: got stall/done/sel=%b want 000",
               {bus.stall, bus.md_done, bus.md_sel});
    end
    run_md(F3_MUL, 32'd3, 32'd4, 32'd12, 33, "post_rst_mul");
    go_idle();
  endtask

  task automatic test_md_disabled();
    bit seen;
    @(negedge clk);
    bus0.inst = mk_r(F7_MULDIV, F3_MUL);
    bus0.ALUOp = 2'b10;
    bus0.valid_in = 1'b1;
    bus0.rs1_val = 32'd3;
    bus0.rs2_val = 32'd4;
    #1;
    checks++;
    if (bus0.ALUSel !== ALU_ADD) begin
      errors++;
      $display("FAIL nomd_alusel: got %0d want %0d", bus0.ALUSel, ALU_ADD);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus0.stall || bus0.md_done || bus0.md_sel) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL nomd_stall: got stall/done/sel activity want none");
    end
    bus0.valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_div_special();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_md_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_md_ctrl
`default_nettype wire
